// File: rtl/ti_bus_pkg.sv
// Shared TI-99/4A bus definitions used by the CRU front end.
// Addresses are A0..A14 with A0 as the most significant bit.
package ti_bus_pkg;

  localparam int TI_ADDR_W = 15;

  localparam logic [3:0] CRU_DEV_PREFIX = 4'b0001;

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    ACTIVE,
    RELEASE
  } cruState_t;

endpackage

// File: rtl/ti_cru_sync_if.sv
// Raw TI CRU pins going in and clean CRU clock/write-strobe signals coming out.
// master drives the raw pins, slave is the synchroniser front end.
interface ti_cru_sync_if;
  import ti_bus_pkg::*;

  logic                 ti_cru_clk_raw;
  logic                 ti_memen_raw;
  logic [0:TI_ADDR_W-1] ti_addr_raw;
  logic                 ti_cru_out_raw;

  logic                 cru_clk;
  logic [0:TI_ADDR_W-1] cru_addr;
  logic                 cru_out;
  logic                 wr_stb;
  logic [0:TI_ADDR_W-1] wr_addr;
  logic                 wr_data;
  logic                 wr_hit;

  modport master (
    output ti_cru_clk_raw, ti_memen_raw, ti_addr_raw, ti_cru_out_raw,
    input  cru_clk, cru_addr, cru_out, wr_stb, wr_addr, wr_data, wr_hit
  );

  modport slave (
    input  ti_cru_clk_raw, ti_memen_raw, ti_addr_raw, ti_cru_out_raw,
    output cru_clk, cru_addr, cru_out, wr_stb, wr_addr, wr_data, wr_hit
  );

endinterface

// File: rtl/ti_cru_sync_sync2.sv
// Two-flop synchroniser for a group of asynchronous inputs.
// RESET_VAL lets idle-high pins such as MEMEN come out of reset inactive.
module sync2 #(
  parameter int                 WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1 <= RESET_VAL;
      r_s2 <= RESET_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/ti_cru_sync.sv
// TI-99/4A CRU front end: synchronises the raw bus, glitch-filters CRUCLK and
// emits one write strobe per qualified CRUCLK rise with captured address/data.
module ti_cru_sync
  import ti_bus_pkg::*;
#(
  parameter int         FILTER_LEN = 3,
  parameter logic [3:0] CRU_BASE   = 4'h2
) (
  input logic          clk,
  input logic          reset,
  ti_cru_sync_if.slave bus
);

  localparam logic [3:0] FILTER_CNT = 4'(FILTER_LEN);

  logic [1:0]           w_ctlS2;
  logic                 w_clkS2;
  logic                 w_outS2;
  logic                 w_memenS2;
  logic [0:TI_ADDR_W-1] w_addrS2;
  logic [3:0]           w_cntInc;
  logic                 w_hit;
  logic                 w_rise;

  cruState_t            r_state;
  logic [3:0]           r_cnt;
  logic                 r_cruClk;
  logic                 r_wrStb;
  logic [0:TI_ADDR_W-1] r_wrAddr;
  logic                 r_wrData;
  logic                 r_wrHit;

  sync2 #(.WIDTH(2), .RESET_VAL(2'b00)) u_syncCtl (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     ({bus.ti_cru_clk_raw, bus.ti_cru_out_raw}),
    .o_q     (w_ctlS2)
  );

  // MEMEN idles high (no memory cycle), so its chain resets to 1.
  sync2 #(.WIDTH(1), .RESET_VAL(1'b1)) u_syncMemen (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (bus.ti_memen_raw),
    .o_q     (w_memenS2)
  );

  sync2 #(.WIDTH(TI_ADDR_W), .RESET_VAL('0)) u_syncAddr (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (bus.ti_addr_raw),
    .o_q     (w_addrS2)
  );

  assign w_clkS2  = w_ctlS2[1];
  assign w_outS2  = w_ctlS2[0];
  assign w_cntInc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
  assign w_hit    = (w_addrS2[0:3] == CRU_DEV_PREFIX) && (w_addrS2[4:7] == CRU_BASE);

  // With FILTER_LEN=1 the rise qualifies straight out of IDLE.
  assign w_rise = w_clkS2 &&
                  (((r_state == IDLE) && (FILTER_CNT == 4'd1)) ||
                   ((r_state == QUAL) && (w_cntInc == FILTER_CNT)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_cruClk <= 1'b0;
      r_wrStb  <= 1'b0;
      r_wrAddr <= '0;
      r_wrData <= 1'b0;
      r_wrHit  <= 1'b0;
    end else begin
      r_wrStb <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cruClk <= 1'b0;
          if (w_clkS2) begin
            if (FILTER_CNT == 4'd1) begin
              r_state  <= ACTIVE;
              r_cnt    <= '0;
              r_cruClk <= 1'b1;
            end else begin
              r_state <= QUAL;
              r_cnt   <= 4'd1;
            end
          end
        end
        QUAL: begin
          if (!w_clkS2) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_cntInc == FILTER_CNT) begin
            r_state  <= ACTIVE;
            r_cnt    <= '0;
            r_cruClk <= 1'b1;
          end else begin
            r_cnt <= w_cntInc;
          end
        end
        ACTIVE: begin
          r_cruClk <= 1'b1;
          if (!w_clkS2) begin
            if (FILTER_CNT == 4'd1) begin
              r_state  <= IDLE;
              r_cnt    <= '0;
              r_cruClk <= 1'b0;
            end else begin
              r_state <= RELEASE;
              r_cnt   <= 4'd1;
            end
          end
        end
        RELEASE: begin
          if (w_clkS2) begin
            r_state <= ACTIVE;
            r_cnt   <= '0;
          end else if (w_cntInc == FILTER_CNT) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_cruClk <= 1'b0;
          end else begin
            r_cnt <= w_cntInc;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_cnt    <= '0;
          r_cruClk <= 1'b0;
        end
      endcase

      // A qualified rise during a memory cycle moves the clock but writes nothing.
      if (w_rise && w_memenS2) begin
        r_wrStb  <= 1'b1;
        r_wrAddr <= w_addrS2;
        r_wrData <= w_outS2;
        r_wrHit  <= w_hit;
      end
    end
  end

  assign bus.cru_clk  = r_cruClk;
  assign bus.cru_addr = w_addrS2;
  assign bus.cru_out  = w_outS2;
  assign bus.wr_stb   = r_wrStb;
  assign bus.wr_addr  = r_wrAddr;
  assign bus.wr_data  = r_wrData;
  assign bus.wr_hit   = r_wrHit;

endmodule

// File: tb/tb_ti_cru_sync.sv
// Directed bench for ti_cru_sync with FILTER_LEN=3, CRU_BASE=2.
// Addresses are given as 16-bit TI byte addresses; the bus carries A0..A14 (addr16 >> 1).
module tb_ti_cru_sync;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ti_cru_sync_if bus ();

  ti_cru_sync #(.FILTER_LEN(3), .CRU_BASE(4'h2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] taAddr(input logic [15:0] addr16);
    return 15'(addr16 >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic clkRaw, input logic memen, input logic [15:0] addr16, input logic dataOut);
    bus.ti_cru_clk_raw = clkRaw;
    bus.ti_memen_raw   = memen;
    bus.ti_addr_raw    = taAddr(addr16);
    bus.ti_cru_out_raw = dataOut;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advances n edges, counting strobes seen and cycles with cru_clk low.
  task automatic runEdges(input int n, output int stbs, output int lows);
    stbs = 0;
    lows = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.wr_stb === 1'b1) stbs++;
      if (bus.cru_clk === 1'b0) lows++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int l;
    int sTot;
    int lTot;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
    step(3);
    checkOutput("reset cru_clk", bus.cru_clk, 0);
    checkOutput("reset wr_stb", bus.wr_stb, 0);
    checkOutput("reset wr_addr", bus.wr_addr, 0);
    checkOutput("reset wr_data", bus.wr_data, 0);
    checkOutput("reset wr_hit", bus.wr_hit, 0);
    reset = 1'b0;
    step(2);

    // Basic write to >1200: strobe on edge 5, fall 5 edges after raw low.
    applyStimulus(1'b1, 1'b1, 16'h1200, 1'b1);
    runEdges(4, s, l);
    checkOutput("t1 no early stb", s, 0);
    checkOutput("t1 clk low edges1-4", l, 4);
    step(1);
    checkOutput("t1 wr_stb edge5", bus.wr_stb, 1);
    checkOutput("t1 cru_clk edge5", bus.cru_clk, 1);
    checkOutput("t1 wr_addr", bus.wr_addr, 32'h0900);
    checkOutput("t1 wr_data", bus.wr_data, 1);
    checkOutput("t1 wr_hit", bus.wr_hit, 1);
    runEdges(5, s, l);
    checkOutput("t1 single stb", s, 0);
    checkOutput("t1 clk held", l, 0);
    checkOutput("t1 cru_addr", bus.cru_addr, 32'h0900);
    checkOutput("t1 cru_out", bus.cru_out, 1);
    applyStimulus(1'b0, 1'b1, 16'h1200, 1'b1);
    runEdges(4, s, l);
    checkOutput("t1 clk high thru fall edge4", l, 0);
    step(1);
    checkOutput("t1 clk fall edge5", bus.cru_clk, 0);

    // Two-cycle glitch must be rejected.
    applyStimulus(1'b1, 1'b1, 16'h1202, 1'b0);
    runEdges(2, s, l);
    sTot = s;
    lTot = l;
    applyStimulus(1'b0, 1'b1, 16'h1202, 1'b0);
    runEdges(8, s, l);
    checkOutput("t2 glitch no stb", sTot + s, 0);
    checkOutput("t2 glitch clk low", lTot + l, 10);
    checkOutput("t2 wr_addr kept", bus.wr_addr, 32'h0900);

    // One-cycle dip inside a valid pulse.
    applyStimulus(1'b1, 1'b1, 16'h1202, 1'b0);
    runEdges(4, s, l);
    checkOutput("t3 no early stb", s, 0);
    runEdges(2, s, l);
    sTot = s;
    lTot = l;
    applyStimulus(1'b0, 1'b1, 16'h1202, 1'b0);
    runEdges(1, s, l);
    sTot += s;
    lTot += l;
    applyStimulus(1'b1, 1'b1, 16'h1202, 1'b0);
    runEdges(5, s, l);
    checkOutput("t3 dip one stb", sTot + s, 1);
    checkOutput("t3 dip clk never low", lTot + l, 0);
    checkOutput("t3 wr_addr", bus.wr_addr, 32'h0901);
    checkOutput("t3 wr_data", bus.wr_data, 0);
    checkOutput("t3 wr_hit", bus.wr_hit, 1);
    applyStimulus(1'b0, 1'b1, 16'h1202, 1'b0);
    runEdges(6, s, l);
    checkOutput("t3 fall timing", l, 2);

    // Off-base address strobes without a hit; MEMEN low suppresses the write.
    applyStimulus(1'b1, 1'b1, 16'h1301, 1'b1);
    runEdges(6, s, l);
    checkOutput("t4 offbase stb", s, 1);
    checkOutput("t4 wr_hit 0", bus.wr_hit, 0);
    checkOutput("t4 wr_addr", bus.wr_addr, 32'h0980);
    applyStimulus(1'b0, 1'b1, 16'h1301, 1'b1);
    runEdges(6, s, l);
    applyStimulus(1'b1, 1'b0, 16'h1200, 1'b0);
    runEdges(6, s, l);
    checkOutput("t4 memen0 no stb", s, 0);
    checkOutput("t4 memen0 clk rises", l, 4);
    checkOutput("t4 memen0 wr_addr kept", bus.wr_addr, 32'h0980);
    checkOutput("t4 memen0 wr_data kept", bus.wr_data, 1);
    applyStimulus(1'b0, 1'b1, 16'h1200, 1'b0);
    runEdges(6, s, l);

    // Reset while ACTIVE with CRUCLK held high re-qualifies as a new rise.
    applyStimulus(1'b1, 1'b1, 16'h1200, 1'b1);
    runEdges(6, s, l);
    checkOutput("t5 pre-reset stb", s, 1);
    reset = 1'b1;
    step(1);
    checkOutput("t5 rst cru_clk", bus.cru_clk, 0);
    checkOutput("t5 rst wr_stb", bus.wr_stb, 0);
    checkOutput("t5 rst wr_addr", bus.wr_addr, 0);
    checkOutput("t5 rst wr_data", bus.wr_data, 0);
    checkOutput("t5 rst wr_hit", bus.wr_hit, 0);
    checkOutput("t5 rst cru_out", bus.cru_out, 0);
    reset = 1'b0;
    runEdges(4, s, l);
    checkOutput("t5 no early stb", s, 0);
    step(1);
    checkOutput("t5 restrobe", bus.wr_stb, 1);
    checkOutput("t5 restrobe addr", bus.wr_addr, 32'h0900);
    applyStimulus(1'b0, 1'b1, 16'h1200, 1'b1);
    runEdges(6, s, l);

    // Back-to-back writes with three low cycles between them.
    applyStimulus(1'b1, 1'b1, 16'h1200, 1'b1);
    runEdges(6, s, l);
    sTot = s;
    checkOutput("t6 first data", bus.wr_data, 1);
    applyStimulus(1'b0, 1'b1, 16'h1200, 1'b1);
    runEdges(3, s, l);
    sTot += s;
    applyStimulus(1'b1, 1'b1, 16'h1202, 1'b0);
    runEdges(6, s, l);
    checkOutput("t6 two strobes", sTot + s, 2);
    checkOutput("t6 final wr_addr", bus.wr_addr, 32'h0901);
    checkOutput("t6 final wr_data", bus.wr_data, 0);
    checkOutput("t6 final wr_hit", bus.wr_hit, 1);
    applyStimulus(1'b0, 1'b1, 16'h1202, 1'b0);
    runEdges(6, s, l);
    checkOutput("t6 idle at end", bus.cru_clk, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
